// File: rtl/cpu_boot_ctrl_if.sv
// cpu_boot_ctrl_if: host-load handshake and instruction-memory write bus.
//   host_valid/host_data/host_last : host -> boot controller word stream
//   host_ready                     : boot controller accepts a word this cycle
//   imem_we/imem_addr/imem_wdata   : registered instruction-memory write port
// Modports: master = host/observer side, slave = boot controller side.
interface cpu_boot_ctrl_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic              host_last;
    logic              host_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output host_valid, host_data, host_last,
        input  host_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  host_valid, host_data, host_last,
        output host_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: loads a program image from a host into instruction memory, holds the
// CPU in reset for HOLD_CYC cycles, releases it, then waits for halt (or watchdog expiry).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : host word handshake in, instruction-memory write port out
//   cpu_rst_n    : active-low reset to the CPU core
//   cpu_halt     : CPU reports halt (only honoured in RUN)
//   wdog_limit   : watchdog run-cycle limit (0 disables)
//   done/timeout : sticky completion flags
// Optional feature: define CPU_BOOT_WDOG_EN to build the run-cycle watchdog; without
// it timeout is tied to 0 and wdog_limit is ignored.
module cpu_boot_ctrl #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_boot_ctrl_if.slave        bus,
    output logic                  cpu_rst_n,
    input  logic                  cpu_halt,
    input  logic [15:0]           wdog_limit,
    output logic                  done,
    output logic                  timeout
);

    typedef enum logic [2:0] {StLoad, StHold, StRun, StHalted, StTimeout} state_e;

    localparam logic [ADDR_W-1:0] CntMax   = '1;
    localparam logic [3:0]        HoldLast = 4'(HOLD_CYC - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [3:0]        hold_q, hold_d;
    logic              host_ready_q, host_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              done_q, done_d;
    logic              xfer;

`ifdef CPU_BOOT_WDOG_EN
    logic [15:0]       wdog_q, wdog_d;
    logic              timeout_q, timeout_d;
`else
    logic              unused_wdog_limit;
    assign unused_wdog_limit = ^wdog_limit;
`endif

    // host_ready is registered and high exactly while in LOAD, so it doubles as the
    // LOAD-state qualifier for the handshake.
    assign xfer = bus.host_valid && host_ready_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_n_d  = cpu_rst_n_q;
        done_d       = done_q;
`ifdef CPU_BOOT_WDOG_EN
        wdog_d       = wdog_q;
        timeout_d    = timeout_q;
`endif
        unique case (state_q)
            StLoad: begin
                if (xfer) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = cnt_q;
                    imem_wdata_d = bus.host_data;
                    // Top address is a forced last word; the counter saturates there.
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                    if (bus.host_last || (cnt_q == CntMax)) begin
                        state_d = StHold;
                        hold_d  = 4'd0;
                    end
                end
            end
            StHold: begin
                if (hold_q == HoldLast) begin
                    state_d     = StRun;
                    cpu_rst_n_d = 1'b1;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            StRun: begin
                // Halt wins over a same-cycle watchdog expiry.
                if (cpu_halt) begin
                    state_d = StHalted;
                    done_d  = 1'b1;
                end
`ifdef CPU_BOOT_WDOG_EN
                else if ((wdog_limit != 16'd0) && (wdog_q == wdog_limit)) begin
                    state_d     = StTimeout;
                    timeout_d   = 1'b1;
                    cpu_rst_n_d = 1'b0;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
`endif
            end
            default: ; // StHalted / StTimeout are terminal
        endcase
        host_ready_d = (state_d == StLoad);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StLoad;
            cnt_q        <= '0;
            hold_q       <= 4'd0;
            host_ready_q <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_n_q  <= 1'b0;
            done_q       <= 1'b0;
`ifdef CPU_BOOT_WDOG_EN
            wdog_q       <= 16'd0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            host_ready_q <= host_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            done_q       <= done_d;
`ifdef CPU_BOOT_WDOG_EN
            wdog_q       <= wdog_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign bus.host_ready = host_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_rst_n      = cpu_rst_n_q;
    assign done           = done_q;
`ifdef CPU_BOOT_WDOG_EN
    assign timeout        = timeout_q;
`else
    assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Testbench for cpu_boot_ctrl: instance A (ADDR_W=10) covers load, hold, halt, watchdog
// and mid-load reset; instance B (ADDR_W=3) covers the forced-last top address.
// Expected imem writes go into per-instance queues and a negedge monitor pops them.
module tb_cpu_boot_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_nb;
    logic        cpu_halt, cpu_halt_b;
    logic [15:0] wdog_limit, wdog_limit_b;
    logic        cpu_rst_n, done, timeout;
    logic        cpu_rst_n_b, done_b, timeout_b;

    cpu_boot_ctrl_if #(.ADDR_W(10), .DATA_W(32)) ifa ();
    cpu_boot_ctrl_if #(.ADDR_W(3),  .DATA_W(32)) ifb ();

    cpu_boot_ctrl #(.ADDR_W(10), .DATA_W(32), .HOLD_CYC(2)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (ifa),
        .cpu_rst_n  (cpu_rst_n),
        .cpu_halt   (cpu_halt),
        .wdog_limit (wdog_limit),
        .done       (done),
        .timeout    (timeout)
    );

    cpu_boot_ctrl #(.ADDR_W(3), .DATA_W(32), .HOLD_CYC(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_nb),
        .bus        (ifb),
        .cpu_rst_n  (cpu_rst_n_b),
        .cpu_halt   (cpu_halt_b),
        .wdog_limit (wdog_limit_b),
        .done       (done_b),
        .timeout    (timeout_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [41:0] qa[$];
    logic [34:0] qb[$];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitors
    always @(negedge clk) begin
        logic [41:0] ea;
        if (ifa.imem_we === 1'b1) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         ifa.imem_addr, ifa.imem_wdata);
            end else begin
                ea = qa.pop_front();
                check("a_sb_addr", 64'(ifa.imem_addr), 64'(ea[41:32]));
                check("a_sb_data", 64'(ifa.imem_wdata), 64'(ea[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [34:0] eb;
        if (ifb.imem_we === 1'b1) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         ifb.imem_addr, ifb.imem_wdata);
            end else begin
                eb = qb.pop_front();
                check("b_sb_addr", 64'(ifb.imem_addr), 64'(eb[34:32]));
                check("b_sb_data", 64'(ifb.imem_wdata), 64'(eb[31:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_n           = 1'b0;
        cpu_halt        = 1'b0;
        ifa.host_valid  = 1'b0;
        ifa.host_last   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Back-to-back burst of n words, last flagged on the final one.
    task automatic load_a(input logic [31:0] base, input int n);
        logic [9:0]  a;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            a = 10'(i);
            d = base + 32'(i);
            check("a_ready_in_load", 64'(ifa.host_ready), 64'd1);
            ifa.host_valid = 1'b1;
            ifa.host_data  = d;
            ifa.host_last  = (i == n - 1);
            qa.push_back({a, d});
            tick();
            check("a_we_latency", 64'(ifa.imem_we), 64'd1);
            check("a_addr_latency", 64'(ifa.imem_addr), 64'(a));
        end
        ifa.host_valid = 1'b0;
        ifa.host_last  = 1'b0;
    endtask

    task automatic wait_run_a();
        int n = 0;
        while (cpu_rst_n !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("a_run_entered", 64'(cpu_rst_n), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [2:0] ab;
        logic [31:0] db;

        rst_n = 1'b0; rst_nb = 1'b0;
        cpu_halt = 1'b0; cpu_halt_b = 1'b0;
        wdog_limit = 16'd0; wdog_limit_b = 16'd0;
        ifa.host_valid = 1'b0; ifa.host_data = '0; ifa.host_last = 1'b0;
        ifb.host_valid = 1'b0; ifb.host_data = '0; ifb.host_last = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_host_ready", 64'(ifa.host_ready), 64'd1);
        check("rst_imem_we", 64'(ifa.imem_we), 64'd0);
        check("rst_imem_addr", 64'(ifa.imem_addr), 64'd0);
        check("rst_imem_wdata", 64'(ifa.imem_wdata), 64'd0);
        check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        rst_n = 1'b1;

        // 4-word load, hold for 2 cycles, release
        load_a(32'hA0, 4);
        check("a_ready_drop", 64'(ifa.host_ready), 64'd0);
        check("a_hold_cyc1", 64'(cpu_rst_n), 64'd0);
        tick();
        check("a_hold_cyc2", 64'(cpu_rst_n), 64'd0);
        tick();
        check("a_run_release", 64'(cpu_rst_n), 64'd1);

        // Halt at run cycle 5 (first RUN cycle counted as 1)
        for (int i = 0; i < 4; i++) tick();
        check("a_done_before_halt", 64'(done), 64'd0);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        check("a_done_after_halt", 64'(done), 64'd1);
        check("a_cpu_rst_n_halted", 64'(cpu_rst_n), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cpu_halt       = i[0];
            ifa.host_valid = 1'b1;
            ifa.host_data  = 32'hDEAD_0000 + 32'(i);
            tick();
            check("a_done_sticky", 64'(done), 64'd1);
            check("a_ready_halted", 64'(ifa.host_ready), 64'd0);
            check("a_no_write_halted", 64'(ifa.imem_we), 64'd0);
        end
        ifa.host_valid = 1'b0;
        cpu_halt = 1'b0;

        // Watchdog expiry with limit 10: RUN cycles counted 0..10, expiry on the 11th
        reset_a();
        wdog_limit = 16'd10;
        load_a(32'hC0, 1);
        wait_run_a();
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
`ifdef CPU_BOOT_WDOG_EN
        check("a_wdog_run_cycles", 64'(n), 64'd11);
        check("a_wdog_timeout", 64'(timeout), 64'd1);
        check("a_wdog_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("a_wdog_done", 64'(done), 64'd0);
`else
        check("a_nowdog_timeout", 64'(timeout), 64'd0);
        check("a_nowdog_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
`endif

        // Halt in the expiry cycle wins
        reset_a();
        wdog_limit = 16'd10;
        load_a(32'hD0, 1);
        wait_run_a();
        for (int i = 0; i < 10; i++) tick();
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        check("a_prio_done", 64'(done), 64'd1);
        check("a_prio_timeout", 64'(timeout), 64'd0);
        check("a_prio_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
        for (int i = 0; i < 3; i++) tick();
        check("a_prio_timeout_later", 64'(timeout), 64'd0);

        // Reset during word 2: no write from it, reload starts at address 0
        reset_a();
        wdog_limit = 16'd0;
        ifa.host_valid = 1'b1;
        ifa.host_data  = 32'h11;
        ifa.host_last  = 1'b0;
        qa.push_back({10'd0, 32'h11});
        tick();
        check("a_mid_word0_we", 64'(ifa.imem_we), 64'd1);
        ifa.host_data = 32'h22;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ifa.host_valid = 1'b0;
        check("a_mid_no_write", 64'(ifa.imem_we), 64'd0);
        check("a_mid_ready", 64'(ifa.host_ready), 64'd1);
        load_a(32'h33, 2);

        // Instance B: 8 words, no host_last, top address ends the load
        rst_nb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ab = 3'(i);
            db = 32'hB0 + 32'(i);
            check("b_ready_in_load", 64'(ifb.host_ready), 64'd1);
            ifb.host_valid = 1'b1;
            ifb.host_data  = db;
            qb.push_back({ab, db});
            tick();
            check("b_addr", 64'(ifb.imem_addr), 64'(ab));
        end
        check("b_ready_after_forced_last", 64'(ifb.host_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            ifb.host_data = 32'hEE + 32'(i);
            tick();
            check("b_no_wrap_write", 64'(ifb.imem_we), 64'd0);
        end
        ifb.host_valid = 1'b0;
        check("b_run_release", 64'(cpu_rst_n_b), 64'd1);

        tick();
        tick();
        check("a_queue_drained", 64'(qa.size()), 64'd0);
        check("b_queue_drained", 64'(qb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_boot_ctrl.md
CPU_BOOT_CTRL -- requirements
Module: cpu_boot_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have parameter HOLD_CYC, default 2, cycles cpu_rst_n stays low after load completes; legal range 1..15.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port host_valid, input, 1, host word offered.
REQ-007 SHALL have port host_data, input, DATA_W, host instruction word.
REQ-008 SHALL have port host_last, input, 1, marks the final word of the image.
REQ-009 SHALL have port host_ready, output, 1, block accepts a word this cycle.
REQ-010 SHALL have port imem_we, output, 1, instruction-memory write strobe.
REQ-011 SHALL have port imem_addr, output, ADDR_W, write address.
REQ-012 SHALL have port imem_wdata, output, DATA_W, write data.
REQ-013 SHALL have port cpu_rst_n, output, 1, active-low reset to the CPU core.
REQ-014 SHALL have port cpu_halt, input, 1, CPU reports halt.
REQ-015 SHALL have port wdog_limit, input, 16, watchdog run-cycle limit.
REQ-016 SHALL have port done, output, 1, CPU halted normally; sticky.
REQ-017 SHALL have port timeout, output, 1, watchdog expired; sticky.

Function
REQ-018 SHALL implement states LOAD, HOLD, RUN, HALTED, TIMEOUT.
REQ-019 SHALL transfer a word only on host_valid && host_ready (same-cycle handshake); host_ready = 1 only in LOAD.
REQ-020 SHALL, on each transfer, assert imem_we for exactly that cycle's following posedge with imem_addr = current word counter and imem_wdata = host_data, both registered (one-cycle latency).
REQ-021 SHALL increment the word counter by 1 per transfer, starting at 0.
REQ-022 SHALL treat counter reaching 2^ADDR_W-1 as forced last: that transfer ends the load, and the counter does not wrap.
REQ-023 SHALL move LOAD->HOLD on the transfer carrying host_last or the forced last.
REQ-024 SHALL keep cpu_rst_n = 0 in LOAD and HOLD; HOLD lasts exactly HOLD_CYC cycles, then HOLD->RUN with cpu_rst_n = 1 from the first RUN cycle.
REQ-025 SHALL, in RUN, go to HALTED on cpu_halt = 1; done = 1 and cpu_rst_n = 1 thereafter.
REQ-026 SHALL ignore cpu_halt outside RUN.
REQ-027 SHALL treat HALTED and TIMEOUT as terminal; only rst_n leaves them.
REQ-028 SHALL ignore host_valid and host_data outside LOAD (host_ready = 0, no imem writes).

Reset
REQ-029 SHALL, while rst_n = 0 at posedge, enter LOAD with counter = 0, HOLD counter = 0, watchdog = 0.
REQ-030 SHALL reset outputs to host_ready = 1 (LOAD), imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_rst_n = 0, done = 0, timeout = 0.
REQ-031 SHALL, on reset mid-load or mid-run, abandon the operation in the same edge; no partial write completes after reset.

Configuration
REQ-032 SHALL compile the watchdog only when macro CPU_BOOT_WDOG_EN is defined.
REQ-033 SHALL, with CPU_BOOT_WDOG_EN, count RUN cycles from 0; when the count equals wdog_limit and cpu_halt = 0, go to TIMEOUT: timeout = 1, cpu_rst_n = 0.
REQ-034 SHALL, with CPU_BOOT_WDOG_EN, give cpu_halt priority over expiry in the same cycle (HALTED); wdog_limit = 0 disables the watchdog.
REQ-035 SHALL, without CPU_BOOT_WDOG_EN, never leave RUN except via cpu_halt, tie timeout to 0 and ignore wdog_limit.

Verification
REQ-036 SHALL check: 4 words 0xA0..0xA3, last on 4th -> imem writes addr 0..3 with matching data, one cycle after each handshake; host_ready drops next cycle.
REQ-037 SHALL check: HOLD_CYC = 2, load ends -> cpu_rst_n low exactly 2 cycles after the last write, then high.
REQ-038 SHALL check: RUN, cpu_halt at run cycle 5 -> done = 1 next cycle, stays 1; further cpu_halt/host_valid no effect.
REQ-039 SHALL check (CPU_BOOT_WDOG_EN): wdog_limit = 10, no halt -> timeout = 1, cpu_rst_n = 0 after 10 RUN cycles; halt on the expiry cycle -> done, not timeout.
REQ-040 SHALL check: ADDR_W = 3, 8 words without host_last -> 8th write at addr 7 ends load, no wrap.
REQ-041 SHALL check: rst_n low during word 2 of a load -> no write from that word, counter 0, reload from addr 0 succeeds.
